turf_header_generator_v3: RTL and testbench
===========================================

Name: turf_header_generator_v3

Overview:
- Next-generation TURF event header builder, single clock domain (sysclk), directly driving an AXI4-Stream header output with real backpressure and TLAST framing.
- Opens a per-trigger metadata window and accumulates TURFIO metadata per slot, first nonzero value wins.
- Queues completed event records so that triggers arriving while earlier headers are still streaming are not lost.
- Parametrised in metadata slot count/width, window length, header length and queue depth; counts dropped triggers.

Parameters:
NUM_META, 32, number of metadata slots
META_BITS, 8, bits per slot; NUM_META*META_BITS must be a multiple of 64
META_WINDOW, 16, window length in cycles, 2..64
HDR_QWORDS, 16, header length in 64-bit qwords; must be >= 4 + NUM_META*META_BITS/64
QUEUE_DEPTH, 4, event record queue depth, power of 2, 2..16
EVENT_FORMAT, 16'h4532, format tag ("E2")
SURF_WORDS, 16'd64, SURF header length in 16-bit words, placed in trailer

Ports:
sysclk_i  in  1  sole clock
sysrst_i  in  1  asynchronous reset, active-high
runrst_i  in  1  run reset pulse: starts run, clears counters, flushes queue
runstop_i  in  1  run stop pulse
tio_mask_i  in  4  TURFIO mask, latched on runrst_i
runcfg_i  in  12  run config, latched on runrst_i
trig_i  in  1  trigger pulse
metadata_i  in  NUM_META*META_BITS  slot metadata, slot m at [m*META_BITS +: META_BITS]
cur_sec_i, cur_time_i, last_pps_i, llast_pps_i  in  32 each  timing inputs
m_thdr_tdata  out  64  header qword
m_thdr_tvalid  out  1  AXI4-S valid
m_thdr_tready  in  1  AXI4-S ready
m_thdr_tlast  out  1  asserted on final qword of each header
event_o  out  1  one-cycle pulse when an event record is queued
dropped_o  out  16  dropped trigger count, saturating
busy_o  out  1  window open OR queue non-empty OR packet in progress

Behaviour:
- Reset (sysrst_i, async): all outputs 0, running=0, queue empty, event counter 0, window closed, run_config 0.
- running: set by runrst_i, cleared by runstop_i; runrst_i wins if both are asserted.
- Window:
  - trig_i with running and window closed opens the window, slot accumulators are cleared, and the four timing inputs are latched that same edge.
  - Window stays open exactly META_WINDOW cycles, including the trig cycle.
  - Per slot, the first nonzero metadata_i sample inside the window is held; later samples are ignored. All-zero slots stay 0.
- trig_i while the window is open: dropped, dropped_o+1; no new window.
- Window close:
  - Queue not full: push {event_counter, times, metadata}, event_counter+1 (32-bit wrap), event_o pulses that cycle.
  - Queue full: record discarded, dropped_o+1.
- Event numbers are contiguous over accepted events only.
- dropped_o saturates at 16'hFFFF.
- Output FSM states:
  - IDLE -> SEND when the queue is non-empty.
  - SEND emits qword index q=0..HDR_QWORDS-1 from the queue head; q advances only on tvalid&&tready.
  - After q=HDR_QWORDS-1 is accepted: pop, return to IDLE.
  - IDLE->SEND adds 1 cycle of bubble.
- Qword map:
  - q0 = {event_num, EVENT_FORMAT, HDR_QWORDS*4-1}
  - q1 = {cur_time, cur_sec}
  - q2 = {llast_pps, last_pps}
  - q3..q(2+NUM_META*META_BITS/64) = metadata, lowest slots first
  - remaining qwords = 0
  - q(HDR_QWORDS-1) = {SURF_WORDS, tio_mask, runcfg, 32'h0}, with tlast=1
- tdata/tlast held stable while tvalid && !tready.
- Latency: a trigger presented to an idle, empty block gives q0 tvalid META_WINDOW+2 cycles after the trig cycle.
- runstop_i:
  - An open window is discarded; this is not counted as a drop.
  - Queued records continue to drain.
- runrst_i:
  - event counter=0, dropped_o=0, run_config latched.
  - All queued records not yet started are flushed.
  - A packet in SEND completes unchanged, so framing is never broken.
  - An open window is discarded.
- Triggers while !running are ignored and not counted.

Optional Feature:
- Macro TURF_HDR_DROPCNT_EN.
- Defined: dropped counter implemented; trailer qword bits [31:16] = dropped_o value at the window close that queued the record, bits [15:0] = 0.
- Undefined: counter logic removed, dropped_o tied to 0, trailer bits [31:0] = 0.

Test Plan:
- Single trigger, runcfg=12'h123, tio_mask=4'hF, slot5=0xA5 at window cycle 3 then 0x11 at cycle 7, tready=1 -> 16 qwords:
  - q0={32'd0,16'h4532,16'd63}
  - slot5 byte=0xA5, other slots 0
  - q15={16'd64,16'hF123,32'h0}, tlast on q15 only
  - event_o single pulse
- tready=0, six triggers spaced 20 cycles -> four queued (event_num 0..3), dropped_o=2; release tready -> four packets in order.
- Second trig_i 5 cycles into open window -> dropped_o=1, one packet only.
- tready toggling 1010... during a packet -> tdata/tlast stable during stalls, exactly 16 beats accepted.
- Mid-stream cases:
  - runrst_i mid-packet with two records queued -> current packet completes, queued records flushed, next trigger has event_num 0.
  - runstop_i mid-window -> no packet, dropped_o unchanged.
- sysrst_i asserted mid-packet -> tvalid, tlast, busy_o and event_o go 0 immediately; after release, no output until a new run and trigger.

Source files
------------

// File: rtl/turf_header_generator_v3.sv
// TURF event header builder: per-trigger metadata window, event record queue and AXI4-Stream header output.
// Build option TURF_HDR_DROPCNT_EN: implements the dropped-trigger counter and its trailer field.
module turf_header_generator_v3 #(
  parameter int          NUM_META     = 32,
  parameter int          META_BITS    = 8,
  parameter int          META_WINDOW  = 16,
  parameter int          HDR_QWORDS   = 16,
  parameter int          QUEUE_DEPTH  = 4,
  parameter logic [15:0] EVENT_FORMAT = 16'h4532,
  parameter logic [15:0] SURF_WORDS   = 16'd64
) (
  input  logic                          sysclk_i,
  input  logic                          sysrst_i,
  input  logic                          runrst_i,
  input  logic                          runstop_i,
  input  logic [3:0]                    tio_mask_i,
  input  logic [11:0]                   runcfg_i,
  input  logic                          trig_i,
  input  logic [NUM_META*META_BITS-1:0] metadata_i,
  input  logic [31:0]                   cur_sec_i,
  input  logic [31:0]                   cur_time_i,
  input  logic [31:0]                   last_pps_i,
  input  logic [31:0]                   llast_pps_i,
  output logic [63:0]                   m_thdr_tdata,
  output logic                          m_thdr_tvalid,
  input  logic                          m_thdr_tready,
  output logic                          m_thdr_tlast,
  output logic                          event_o,
  output logic [15:0]                   dropped_o,
  output logic                          busy_o
);
  localparam int MW      = NUM_META * META_BITS;
  localparam int META_QW = MW / 64;
  localparam int QIW     = $clog2(HDR_QWORDS);
  localparam int PW      = $clog2(QUEUE_DEPTH);
  localparam int CW      = PW + 1;
  localparam logic [6:0]     WIN_LAST = 7'(META_WINDOW - 1);
  localparam logic [QIW-1:0] Q_LAST   = QIW'(HDR_QWORDS - 1);
  localparam logic [CW-1:0]  Q_FULL   = CW'(QUEUE_DEPTH);

  typedef struct packed {
    logic [31:0]   evn;
    logic [31:0]   cur_sec;
    logic [31:0]   cur_time;
    logic [31:0]   last_pps;
    logic [31:0]   llast_pps;
    logic [MW-1:0] meta;
    logic [15:0]   cfg;
    logic [15:0]   drop;
  } rec_t;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  function automatic logic [63:0] qword(input rec_t r, input logic [QIW-1:0] q);
    logic [63:0] w;
    int          qi;
    w  = '0;
    qi = int'(q);
    if (qi == 0)                   w = {r.evn, EVENT_FORMAT, 16'(HDR_QWORDS*4 - 1)};
    else if (qi == 1)              w = {r.cur_time, r.cur_sec};
    else if (qi == 2)              w = {r.llast_pps, r.last_pps};
    else if (qi == HDR_QWORDS - 1) w = {SURF_WORDS, r.cfg, r.drop, 16'h0};
    else
      for (int k = 0; k < META_QW; k++)
        if (qi == 3 + k) w = r.meta[k*64 +: 64];
    return w;
  endfunction

  logic              running_q, win_q, event_q;
  logic [15:0]       cfg_q;
  logic [6:0]        wcnt_q;
  logic [31:0]       evn_q, sec_q, time_q, lpps_q, llpps_q;
  logic [MW-1:0]     acc_q, acc_d;
  rec_t              mem_q [QUEUE_DEPTH];
  rec_t              new_rec, head;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_n;
  logic [CW-1:0]     count_q;
  state_t            state_q;
  logic [QIW-1:0]    qidx_q, qidx_n;
  logic              tvalid_q, tlast_q;
  logic [63:0]       tdata_q;
  logic [15:0]       drop_snap;

  logic ctl_ok, win_open, win_last, close, full, push, pop, keep;
  assign ctl_ok   = !runrst_i && !runstop_i;
  assign win_open = ctl_ok && running_q && !win_q && trig_i;
  assign win_last = win_q && (wcnt_q == WIN_LAST);
  assign close    = ctl_ok && win_last;
  assign full     = (count_q == Q_FULL);
  assign push     = close && !full;
  assign pop      = tvalid_q && m_thdr_tready && tlast_q;
  assign keep     = (state_q == S_SEND) && !pop;
  assign rd_ptr_n = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign head     = mem_q[rd_ptr_q];
  assign qidx_n   = qidx_q + 1'b1;

  // First nonzero sample per slot wins; the trigger edge reloads every slot.
  always_comb begin
    acc_d = acc_q;
    for (int m = 0; m < NUM_META; m++)
      if (win_open || (win_q && acc_q[m*META_BITS +: META_BITS] == '0))
        acc_d[m*META_BITS +: META_BITS] = metadata_i[m*META_BITS +: META_BITS];
  end

  always_comb begin
    new_rec.evn       = evn_q;
    new_rec.cur_sec   = sec_q;
    new_rec.cur_time  = time_q;
    new_rec.last_pps  = lpps_q;
    new_rec.llast_pps = llpps_q;
    new_rec.meta      = acc_d;
    new_rec.cfg       = cfg_q;
    new_rec.drop      = drop_snap;
  end

`ifdef TURF_HDR_DROPCNT_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [15:0] drop_q;
  logic        drop_trig, drop_full;
  assign drop_trig = ctl_ok && win_q && trig_i;
  assign drop_full = close && full;
  assign drop_snap = drop_q;
  assign dropped_o = drop_q;

  always_ff @(posedge sysclk_i or posedge sysrst_i)
    if (sysrst_i)      drop_q <= '0;
    else if (runrst_i) drop_q <= '0;
    else               drop_q <= sat_add16(drop_q, 2'(drop_trig) + 2'(drop_full));
`else
  assign drop_snap = '0;
  assign dropped_o = '0;
`endif

  // Run control and metadata window
  always_ff @(posedge sysclk_i or posedge sysrst_i)
    if (sysrst_i) begin
      running_q <= 1'b0;
      cfg_q     <= '0;
      win_q     <= 1'b0;
      wcnt_q    <= '0;
      evn_q     <= '0;
      event_q   <= 1'b0;
    end else begin
      event_q <= push;
      if (runrst_i) begin
        running_q <= 1'b1;
        cfg_q     <= {tio_mask_i, runcfg_i};
        win_q     <= 1'b0;
        evn_q     <= '0;
      end else if (runstop_i) begin
        running_q <= 1'b0;
        win_q     <= 1'b0;
      end else if (win_q) begin
        if (win_last) win_q  <= 1'b0;
        else          wcnt_q <= wcnt_q + 7'd1;
        if (push) evn_q <= evn_q + 32'd1;
      end else if (win_open) begin
        win_q  <= 1'b1;
        wcnt_q <= 7'd1;
      end
    end

  always_ff @(posedge sysclk_i) begin
    acc_q <= acc_d;
    if (win_open) begin
      sec_q   <= cur_sec_i;
      time_q  <= cur_time_i;
      lpps_q  <= last_pps_i;
      llpps_q <= llast_pps_i;
    end
    if (push) mem_q[wr_ptr_q] <= new_rec;
  end

  // Record queue: a run reset keeps only a record whose packet has already started
  always_ff @(posedge sysclk_i or posedge sysrst_i)
    if (sysrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_n;
      if (runrst_i) begin
        wr_ptr_q <= keep ? rd_ptr_n + 1'b1 : rd_ptr_n;
        count_q  <= keep ? CW'(1) : '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (!push && pop) count_q <= count_q - 1'b1;
      end
    end

  // Output framing FSM
  always_ff @(posedge sysclk_i or posedge sysrst_i)
    if (sysrst_i) begin
      state_q  <= S_IDLE;
      qidx_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE:
          if (count_q != '0 && !runrst_i) begin
            state_q <= S_SEND;
            qidx_q  <= '0;
          end
        S_SEND:
          if (!tvalid_q) begin
            tvalid_q <= 1'b1;
            tdata_q  <= qword(head, '0);
            tlast_q  <= (Q_LAST == '0);
          end else if (m_thdr_tready) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              tdata_q <= qword(head, qidx_n);
              tlast_q <= (qidx_n == Q_LAST);
              qidx_q  <= qidx_n;
            end
          end
        default: state_q <= S_IDLE;
      endcase
    end

  assign m_thdr_tdata  = tdata_q;
  assign m_thdr_tvalid = tvalid_q;
  assign m_thdr_tlast  = tlast_q;
  assign event_o       = event_q;
  assign busy_o        = win_q || (count_q != '0) || (state_q != S_IDLE);
endmodule

// File: tb/tb_turf_header_generator_v3.sv
// Randomized and directed bench for turf_header_generator_v3 against an event-level reference model.
module tb_turf_header_generator_v3;
  localparam int NUM_META = 32, META_BITS = 8, META_WINDOW = 16, HDR_QWORDS = 16, QUEUE_DEPTH = 4;
  localparam int MW = NUM_META * META_BITS;
  localparam int META_QW = MW / 64;
  typedef logic [HDR_QWORDS*64-1:0] pkt_t;

  logic          sysclk = 1'b0, sysrst = 1'b1, runrst = 1'b0, runstop = 1'b0, trig = 1'b0, tready = 1'b1;
  logic [3:0]    tio_mask = '0;
  logic [11:0]   runcfg = '0;
  logic [MW-1:0] metadata = '0;
  logic [31:0]   cur_sec = '0, cur_time = '0, last_pps = '0, llast_pps = '0;
  logic [63:0]   tdata;
  logic          tvalid, tlast, event_o;
  logic [15:0]   dropped_o;
  logic          busy_o;

  turf_header_generator_v3 dut (
    .sysclk_i(sysclk), .sysrst_i(sysrst), .runrst_i(runrst), .runstop_i(runstop),
    .tio_mask_i(tio_mask), .runcfg_i(runcfg), .trig_i(trig), .metadata_i(metadata),
    .cur_sec_i(cur_sec), .cur_time_i(cur_time), .last_pps_i(last_pps), .llast_pps_i(llast_pps),
    .m_thdr_tdata(tdata), .m_thdr_tvalid(tvalid), .m_thdr_tready(tready), .m_thdr_tlast(tlast),
    .event_o(event_o), .dropped_o(dropped_o), .busy_o(busy_o)
  );

  always #5 sysclk = ~sysclk;

  int n_vec = 0, n_err = 0;
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: run state, window, expected packets
  bit          m_run, m_win, exp_event, m_popped, m_keep;
  int          m_wcnt, m_drop, m_beat, m_occ, m_ndrop, n_pkts = 0;
  logic [31:0] m_evn, m_sec, m_time, m_lpps, m_llpps;
  logic [15:0] m_cfg;
  logic [7:0]  m_slot [NUM_META];
  logic [MW-1:0] m_meta;
  pkt_t        exp_q [$];
  pkt_t        m_h;

  function automatic logic [15:0] exp_drop();
`ifdef TURF_HDR_DROPCNT_EN
    return 16'(m_drop);
`else
    return 16'h0;
`endif
  endfunction

  always @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      m_run = 0; m_win = 0; m_evn = '0; m_drop = 0; m_cfg = '0; m_beat = 0; exp_event = 0;
      exp_q.delete();
    end else begin
      m_occ = exp_q.size(); m_popped = 0; m_ndrop = 0; exp_event = 0;
      if (tvalid && tready) begin
        if (m_occ == 0) check_val("beat_without_record", 64'(tvalid), 64'(0));
        else begin
          m_h = exp_q[0];
          check_val("tdata", tdata, m_h[m_beat*64 +: 64]);
          check_val("tlast", 64'(tlast), 64'(m_beat == HDR_QWORDS - 1));
          m_beat++;
          if (m_beat == HDR_QWORDS) begin
            void'(exp_q.pop_front()); m_beat = 0; m_popped = 1; n_pkts++;
          end
        end
      end
      if (runrst) begin
        m_keep = (exp_q.size() > 0) && (m_beat > 0 || (tvalid && !m_popped));
        while (exp_q.size() > (m_keep ? 1 : 0)) void'(exp_q.pop_back());
        m_run = 1; m_win = 0; m_evn = '0; m_drop = 0; m_cfg = {tio_mask, runcfg};
      end else if (runstop) begin
        m_run = 0; m_win = 0;
      end else if (m_run) begin
        if (m_win) begin
          for (int m = 0; m < NUM_META; m++)
            if (m_slot[m] == 8'h0) m_slot[m] = metadata[m*8 +: 8];
          if (trig) m_ndrop++;
          if (m_wcnt == META_WINDOW - 1) begin
            m_win = 0;
            if (m_occ == QUEUE_DEPTH) m_ndrop++;
            else begin
              for (int m = 0; m < NUM_META; m++) m_meta[m*8 +: 8] = m_slot[m];
              m_h = '0;
              m_h[0 +: 64]   = {m_evn, 16'h4532, 16'd63};
              m_h[64 +: 64]  = {m_time, m_sec};
              m_h[128 +: 64] = {m_llpps, m_lpps};
              for (int k = 0; k < META_QW; k++) m_h[(3+k)*64 +: 64] = m_meta[k*64 +: 64];
              m_h[(HDR_QWORDS-1)*64 +: 64] = {16'd64, m_cfg, exp_drop(), 16'h0};
              exp_q.push_back(m_h);
              m_evn = m_evn + 1; exp_event = 1;
            end
          end else m_wcnt++;
        end else if (trig) begin
          m_win = 1; m_wcnt = 1;
          for (int m = 0; m < NUM_META; m++) m_slot[m] = metadata[m*8 +: 8];
          m_sec = cur_sec; m_time = cur_time; m_lpps = last_pps; m_llpps = llast_pps;
        end
      end
      m_drop = (m_drop + m_ndrop > 65535) ? 65535 : m_drop + m_ndrop;
    end
  end

  // Capture of delivered beats
  logic [63:0] cap_q [HDR_QWORDS];
  int          cap_i = 0, n_beats = 0, n_events = 0;
  always @(posedge sysclk or posedge sysrst)
    if (sysrst) cap_i = 0;
    else if (tvalid && tready) begin
      if (cap_i < HDR_QWORDS) cap_q[cap_i] = tdata;
      cap_i = tlast ? 0 : cap_i + 1;
      n_beats++;
    end

  bit          prev_stall = 0, prev_last;
  logic [63:0] prev_data;
  always @(negedge sysclk)
    if (sysrst) prev_stall = 0;
    else begin
      if (event_o) n_events++;
      check_val("event_o", 64'(event_o), 64'(exp_event));
      check_val("dropped_o", 64'(dropped_o), 64'(exp_drop()));
      check_val("busy_o", 64'(busy_o), 64'(m_win || exp_q.size() > 0));
      if (exp_q.size() == 0) check_val("idle_tvalid", 64'(tvalid), 64'(0));
      if (prev_stall) begin
        check_val("stall_tvalid", 64'(tvalid), 64'(1));
        check_val("stall_tdata", tdata, prev_data);
        check_val("stall_tlast", 64'(tlast), 64'(prev_last));
      end
      prev_stall = tvalid && !tready; prev_data = tdata; prev_last = tlast;
    end

  task automatic tick();
    @(posedge sysclk); #2;
    cur_sec = $urandom; cur_time = $urandom; last_pps = $urandom; llast_pps = $urandom;
  endtask
  task automatic do_runrst(input logic [11:0] cfg, input logic [3:0] mask);
    runcfg = cfg; tio_mask = mask; runrst = 1'b1; tick(); runrst = 1'b0;
  endtask
  task automatic pulse_trig();
    trig = 1'b1; tick(); trig = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin tick(); n++; end
    check_val("idle_timeout", 64'(busy_o), 64'(0));
    repeat (2) tick();
  endtask

  int p0, b0, e0, lat;
  bit tb_run;
  logic [15:0] d2 = 16'd2, d1 = 16'd1;

  initial begin
    repeat (3) tick();
    check_val("rst_tvalid", 64'(tvalid), 64'(0));
    check_val("rst_tlast", 64'(tlast), 64'(0));
    check_val("rst_tdata", tdata, 64'(0));
    check_val("rst_busy", 64'(busy_o), 64'(0));
    check_val("rst_dropped", 64'(dropped_o), 64'(0));
    sysrst = 1'b0;
    tick();

    // Single trigger with two metadata writes to slot 5
    do_runrst(12'h123, 4'hF);
    p0 = n_pkts; e0 = n_events;
    trig = 1'b1; tick(); trig = 1'b0; lat = 1;
    while (!tvalid && lat < 60) begin
      if (lat == 3) metadata[5*8 +: 8] = 8'hA5;
      if (lat == 4 || lat == 8) metadata = '0;
      if (lat == 7) metadata[5*8 +: 8] = 8'h11;
      tick(); lat++;
    end
    check_val("t1_latency", 64'(lat), 64'(META_WINDOW + 2));
    wait_idle(100);
    check_val("t1_pkts", 64'(n_pkts - p0), 64'(1));
    check_val("t1_events", 64'(n_events - e0), 64'(1));
    check_val("t1_q0", cap_q[0], {32'd0, 16'h4532, 16'd63});
    check_val("t1_q3", cap_q[3], 64'h0000_A500_0000_0000);
    check_val("t1_q4", cap_q[4], 64'h0);
    check_val("t1_q15", cap_q[15], {16'd64, 16'hF123, 32'h0});

    // Trigger inside an open window is dropped
    do_runrst(12'h0AB, 4'h3);
    p0 = n_pkts;
    pulse_trig(); repeat (4) tick(); pulse_trig();
    wait_idle(100);
    check_val("t3_pkts", 64'(n_pkts - p0), 64'(1));
`ifdef TURF_HDR_DROPCNT_EN
    check_val("t3_dropped", 64'(dropped_o), 64'(d1));
`else
    check_val("t3_dropped", 64'(dropped_o), 64'(0));
`endif

    // Alternating tready during one packet
    do_runrst(12'h456, 4'h5);
    b0 = n_beats;
    pulse_trig();
    for (int i = 0; i < 200 && busy_o; i++) begin tready = ~tready; tick(); end
    tready = 1'b1;
    wait_idle(50);
    check_val("t4_beats", 64'(n_beats - b0), 64'(HDR_QWORDS));

    // Stalled output: queue fills, overflow records dropped
    tready = 1'b0;
    do_runrst(12'h777, 4'hA);
    p0 = n_pkts;
    for (int i = 0; i < 6; i++) begin pulse_trig(); repeat (19) tick(); end
    check_val("t2_pending", 64'(n_pkts - p0), 64'(0));
`ifdef TURF_HDR_DROPCNT_EN
    check_val("t2_dropped", 64'(dropped_o), 64'(d2));
`else
    check_val("t2_dropped", 64'(dropped_o), 64'(0));
`endif
    tready = 1'b1;
    wait_idle(300);
    check_val("t2_pkts", 64'(n_pkts - p0), 64'(QUEUE_DEPTH));

    // Run reset mid-packet with two records waiting
    tready = 1'b0;
    do_runrst(12'h111, 4'h1);
    p0 = n_pkts;
    for (int i = 0; i < 3; i++) begin pulse_trig(); repeat (19) tick(); end
    tready = 1'b1;
    for (int i = 0; i < 100 && cap_i < 5; i++) tick();
    check_val("t5_midpacket", 64'(tvalid), 64'(1));
    runcfg = 12'h222; runrst = 1'b1; tick(); runrst = 1'b0;
    wait_idle(100);
    check_val("t5_flushed", 64'(n_pkts - p0), 64'(1));
    pulse_trig();
    wait_idle(100);
    check_val("t5_pkts", 64'(n_pkts - p0), 64'(2));
    check_val("t5_evnum", 64'(cap_q[0][63:32]), 64'(0));

    // Run stop mid-window, then triggers while stopped
    do_runrst(12'h333, 4'h2);
    p0 = n_pkts;
    pulse_trig(); repeat (4) tick();
    runstop = 1'b1; tick(); runstop = 1'b0;
    repeat (30) tick();
    pulse_trig(); repeat (25) tick();
    check_val("t6_pkts", 64'(n_pkts - p0), 64'(0));
    check_val("t6_dropped", 64'(dropped_o), 64'(0));
    check_val("t6_busy", 64'(busy_o), 64'(0));

    // System reset mid-packet
    do_runrst(12'h444, 4'h4);
    pulse_trig();
    for (int i = 0; i < 60 && cap_i < 3; i++) tick();
    @(negedge sysclk); #1 sysrst = 1'b1; #1;
    check_val("t7_tvalid", 64'(tvalid), 64'(0));
    check_val("t7_tlast", 64'(tlast), 64'(0));
    check_val("t7_busy", 64'(busy_o), 64'(0));
    check_val("t7_event", 64'(event_o), 64'(0));
    repeat (3) tick();
    sysrst = 1'b0;
    p0 = n_pkts;
    for (int i = 0; i < 4; i++) begin pulse_trig(); repeat (9) tick(); end
    check_val("t7_no_output", 64'(n_pkts - p0), 64'(0));
    check_val("t7_tvalid_after", 64'(tvalid), 64'(0));

    // Randomized traffic
    do_runrst(12'($urandom), 4'($urandom)); tb_run = 1;
    for (int c = 0; c < 4000; c++) begin
      trig   = ($urandom_range(0, 11) == 0);
      tready = ($urandom_range(0, 3) != 0);
      for (int m = 0; m < NUM_META; m++)
        metadata[m*8 +: 8] = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h0;
      runstop = tb_run && ($urandom_range(0, 599) == 0);
      runrst  = !runstop && (tvalid || exp_q.size() == 0) &&
                ($urandom_range(0, tb_run ? 799 : 49) == 0);
      if (runrst) begin runcfg = 12'($urandom); tio_mask = 4'($urandom); tb_run = 1; end
      if (runstop) tb_run = 0;
      tick();
    end
    trig = 1'b0; runstop = 1'b0; runrst = 1'b0; tready = 1'b1; metadata = '0;
    wait_idle(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
